// File: rtl/lcd_figure_arbiter.sv
// Round-robin arbiter for three figure-update requesters sharing one LCD write engine.
// Each requester keeps one pending code. An issued figure stays on the display for a minimum hold time.
module lcd_figure_arbiter #(
  parameter int unsigned HOLD_CYCLES    = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [11:0] fig,
  input  logic        lcd_done,
  output logic        lcd_start,
  output logic [3:0]  lcd_figure,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned MAXC = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLD} state_t;

  state_t      state, state_nx;
  logic [2:0]  pending;
  logic [3:0]  code [3];
  logic [1:0]  last_grant;
  logic [1:0]  winner;
  logic [1:0]  pick;
  logic        pick_valid;
  int unsigned rr_idx;
  logic [CW-1:0] cnt;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        set_to;

  // Round-robin search starting one past the last grant.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    rr_idx     = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      rr_idx = (32'(last_grant) + 32'd1 + k) % 32'd3;
      if (!pick_valid && pending[rr_idx]) begin
        pick_valid = 1'b1;
        pick       = 2'(rr_idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    set_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = WAIT_DONE;
        cnt_clr  = 1'b1;
      end
      WAIT_DONE: begin
        if (lcd_done) begin
          state_nx = HOLD;
          cnt_clr  = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_nx = HOLD;
          cnt_clr  = 1'b1;
          set_to   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) state_nx = IDLE;
        else                  cnt_inc  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Start/ack are gated by reset so that a reset in the ISSUE cycle emits nothing.
  always_comb begin
    lcd_start = (state == ISSUE) && !reset;
    ack       = lcd_start ? (3'b001 << winner) : '0;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      last_grant  <= 2'd2;
      winner      <= '0;
      cnt         <= '0;
      lcd_figure  <= '0;
      timeout_err <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) code[i] <= '0;
    end else begin
      state <= state_nx;

      if (cnt_clr)                 cnt <= '0;
      else if (cnt_inc && cnt != '1) cnt <= cnt + 1'b1;

      if (set_to) timeout_err <= 1'b1;

      // A request arriving in the decision cycle forwards its fresh code.
      if (state == IDLE && pick_valid) begin
        winner     <= pick;
        lcd_figure <= req[pick] ? fig[4*pick +: 4] : code[pick];
      end

      if (state == ISSUE) last_grant <= winner;

      for (int unsigned i = 0; i < 3; i++) begin
        if (req[i]) begin
          pending[i] <= 1'b1;
          code[i]    <= fig[4*i +: 4];
        end else if (state == ISSUE && 32'(winner) == i) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule
